// File: rtl/branch_predictor_gshare_ras_pkg.sv
// Shared types and helpers for the gshare + BTB + RAS fetch predictor.
package branch_predictor_gshare_ras_pkg;

  localparam int DataBusBits = 64;

  typedef enum logic [1:0] {
    BrTypeBranch = 2'b00,
    BrTypeJump   = 2'b01,
    BrTypeCall   = 2'b10,
    BrTypeReturn = 2'b11
  } br_type_e;

  localparam logic [1:0] PhtResetValue = 2'b01;

  // Two-bit saturating direction counter; bit 1 is the taken prediction.
  function automatic logic [1:0] sat_counter_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_ras_ras.sv
// Circular return address stack: push overwrites the oldest entry when full,
// pop on empty is ignored. State changes on the falling clock edge.
module return_address_stack #(
  parameter int RAS_DEPTH = 8,
  parameter int WIDTH     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int PtrBits = $clog2(RAS_DEPTH);
  localparam logic [PtrBits:0] FullCount = (PtrBits + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0]   entries_q [RAS_DEPTH];
  logic [PtrBits-1:0] ptr_q, ptr_d;     // next free slot; top lives at ptr_q - 1
  logic [PtrBits:0]   count_q, count_d;

  assign empty = (count_q == '0);
  assign top   = entries_q[ptr_q - 1'b1];

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_q + 1'b1;
      if (count_q != FullCount) count_d = count_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage arrays are not reset; pointer and count alone define what is live.
  always_ff @(negedge clk) begin
    if (!reset && push) entries_q[ptr_q] <= pushData;
  end

endmodule

// File: rtl/branch_predictor_gshare_ras.sv
// Fetch-stage next-PC predictor: gshare direction, direct-mapped typed BTB,
// return address stack and saturating perf counters, trained from execute.
module branch_predictor_gshare_ras
  import branch_predictor_gshare_ras_pkg::*;
#(
  parameter int GHR_BITS  = 8,
  parameter int BTB_BITS  = 6,
  parameter int RAS_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DataBusBits-1:0] PC,
  output logic [DataBusBits-1:0] PCPlus4,
  output logic [DataBusBits-1:0] PCPrediction,
  output logic                   predTaken,
  input  logic                   we,
  input  logic [DataBusBits-1:0] PCUpdate,
  input  logic [DataBusBits-1:0] targetUpdate,
  input  logic                   takenUpdate,
  input  logic [1:0]             typeUpdate,
  input  logic                   mispredict,
  output logic [31:0]            branchCount,
  output logic [31:0]            mispredictCount
);

  localparam int BtbEntries = 2 ** BTB_BITS;
  localparam int PhtEntries = 2 ** GHR_BITS;
  localparam int TagBits    = DataBusBits - BTB_BITS - 2;

  logic                   btb_valid_q  [BtbEntries];
  br_type_e               btb_type_q   [BtbEntries];
  logic [TagBits-1:0]     btb_tag_q    [BtbEntries];
  logic [DataBusBits-1:0] btb_target_q [BtbEntries];
  logic [1:0]             pht_q        [PhtEntries];

  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         branch_count_q, branch_count_d;
  logic [31:0]         mispredict_count_q, mispredict_count_d;

  logic [BTB_BITS-1:0]    look_btb_idx, upd_btb_idx;
  logic [TagBits-1:0]     look_tag, upd_tag;
  logic [GHR_BITS-1:0]    look_pht_idx, upd_pht_idx;
  logic                   look_hit;
  logic                   upd_is_branch, btb_write;
  logic [DataBusBits-1:0] ras_top;
  logic                   ras_empty;

  assign PCPlus4 = PC + DataBusBits'(4);

  assign look_btb_idx = PC[BTB_BITS+1:2];
  assign look_tag     = PC[DataBusBits-1:BTB_BITS+2];
  assign look_pht_idx = PC[GHR_BITS+1:2] ^ ghr_q;
  assign look_hit     = btb_valid_q[look_btb_idx] && (btb_tag_q[look_btb_idx] == look_tag);

  always_comb begin
    PCPrediction = PCPlus4;
    predTaken    = 1'b0;
    if (look_hit) begin
      unique case (btb_type_q[look_btb_idx])
        BrTypeBranch: begin
          if (pht_q[look_pht_idx][1]) begin
            PCPrediction = btb_target_q[look_btb_idx];
            predTaken    = 1'b1;
          end
        end
        BrTypeJump, BrTypeCall: begin
          PCPrediction = btb_target_q[look_btb_idx];
          predTaken    = 1'b1;
        end
        BrTypeReturn: begin
          PCPrediction = ras_empty ? btb_target_q[look_btb_idx] : ras_top;
          predTaken    = 1'b1;
        end
      endcase
    end
  end

  assign upd_btb_idx   = PCUpdate[BTB_BITS+1:2];
  assign upd_tag       = PCUpdate[DataBusBits-1:BTB_BITS+2];
  assign upd_pht_idx   = PCUpdate[GHR_BITS+1:2] ^ ghr_q;
  assign upd_is_branch = (typeUpdate == BrTypeBranch);
  // A not-taken branch never allocates, so fall-through branches do not pollute the BTB.
  assign btb_write     = we && !(upd_is_branch && !takenUpdate);

  always_comb begin
    ghr_d              = ghr_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (we) begin
      if (upd_is_branch) begin
        ghr_d = {ghr_q[GHR_BITS-2:0], takenUpdate};
        if (branch_count_q != '1) branch_count_d = branch_count_q + 32'd1;
      end
      if (mispredict && (mispredict_count_q != '1)) mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      ghr_q              <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      ghr_q              <= ghr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < BtbEntries; i++) btb_valid_q[i] <= 1'b0;
      for (int i = 0; i < PhtEntries; i++) pht_q[i] <= PhtResetValue;
    end else begin
      if (btb_write) btb_valid_q[upd_btb_idx] <= 1'b1;
      if (we && upd_is_branch) pht_q[upd_pht_idx] <= sat_counter_step(pht_q[upd_pht_idx], takenUpdate);
    end
  end

  always_ff @(negedge clk) begin
    if (!reset && btb_write) begin
      btb_type_q[upd_btb_idx]   <= br_type_e'(typeUpdate);
      btb_tag_q[upd_btb_idx]    <= upd_tag;
      btb_target_q[upd_btb_idx] <= targetUpdate;
    end
  end

  return_address_stack #(
    .RAS_DEPTH(RAS_DEPTH),
    .WIDTH    (DataBusBits)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (we && (typeUpdate == BrTypeCall)),
    .pop     (we && (typeUpdate == BrTypeReturn)),
    .pushData(PCUpdate + DataBusBits'(4)),
    .top     (ras_top),
    .empty   (ras_empty)
  );

  assign branchCount     = branch_count_q;
  assign mispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_gshare_ras.sv
// Self-checking bench: directed vector table, hand sequences for RAS overflow,
// counters and reset-vs-update, then random traffic against a behavioural model.
module tb_branch_predictor_gshare_ras;

  localparam int GHR_BITS  = 8;
  localparam int BTB_BITS  = 6;
  localparam int RAS_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] PC = '0;
  logic [63:0] PCPlus4, PCPrediction;
  logic        predTaken;
  logic        we = 1'b0;
  logic [63:0] PCUpdate = '0, targetUpdate = '0;
  logic        takenUpdate = 1'b0;
  logic [1:0]  typeUpdate = 2'b00;
  logic        mispredict = 1'b0;
  logic [31:0] branchCount, mispredictCount;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare_ras #(
    .GHR_BITS(GHR_BITS), .BTB_BITS(BTB_BITS), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .PC(PC), .PCPlus4(PCPlus4), .PCPrediction(PCPrediction),
    .predTaken(predTaken), .we(we), .PCUpdate(PCUpdate), .targetUpdate(targetUpdate),
    .takenUpdate(takenUpdate), .typeUpdate(typeUpdate), .mispredict(mispredict),
    .branchCount(branchCount), .mispredictCount(mispredictCount)
  );

  // ---------------- behavioural reference model ----------------
  localparam int BtbN = 1 << BTB_BITS;
  localparam int PhtN = 1 << GHR_BITS;
  bit          m_valid  [BtbN];
  logic [63:0] m_pc     [BtbN];   // full resolved PC kept; hit compares everything above the index
  int          m_type   [BtbN];
  logic [63:0] m_target [BtbN];
  int          m_pht    [PhtN];
  int          m_ghr;
  logic [63:0] m_ras[$];
  longint      m_branches, m_mispredicts;

  function automatic void m_reset();
    for (int i = 0; i < BtbN; i++) m_valid[i] = 0;
    for (int i = 0; i < PhtN; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_ras.delete();
    m_branches = 0;
    m_mispredicts = 0;
  endfunction

  function automatic int btb_slot(input logic [63:0] pc);
    return int'((pc / 4) % BtbN);
  endfunction

  function automatic int pht_slot(input logic [63:0] pc);
    return int'((pc / 4) % PhtN) ^ m_ghr;
  endfunction

  function automatic void m_update(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                                   input int typ, input logic mp);
    int s, p;
    s = btb_slot(pc);
    p = pht_slot(pc);
    if (!(typ == 0 && !taken)) begin
      m_valid[s] = 1; m_pc[s] = pc; m_type[s] = typ; m_target[s] = tgt;
    end
    if (typ == 0) begin
      m_pht[p] = taken ? ((m_pht[p] < 3) ? m_pht[p] + 1 : 3) : ((m_pht[p] > 0) ? m_pht[p] - 1 : 0);
      m_ghr = ((m_ghr * 2) + int'(taken)) % PhtN;
      if (m_branches < 64'hFFFF_FFFF) m_branches++;
    end
    if (typ == 2) begin
      if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
      m_ras.push_back(pc + 64'd4);
    end
    if (typ == 3 && m_ras.size() > 0) void'(m_ras.pop_back());
    if (mp && m_mispredicts < 64'hFFFF_FFFF) m_mispredicts++;
  endfunction

  function automatic void m_predict(input logic [63:0] pc, output logic [63:0] pred, output logic tk);
    int s;
    s = btb_slot(pc);
    pred = pc + 64'd4;
    tk = 0;
    if (m_valid[s] && (m_pc[s] >> (BTB_BITS + 2)) == (pc >> (BTB_BITS + 2))) begin
      if (m_type[s] != 0 || m_pht[pht_slot(pc)] >= 2) begin
        tk = 1;
        pred = (m_type[s] == 3 && m_ras.size() > 0) ? m_ras[$] : m_target[s];
      end
    end
  endfunction

  // ---------------- bench utilities ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_update(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                           input int typ, input logic mp, input logic rst);
    @(posedge clk); #1;
    we = 1'b1; PCUpdate = pc; targetUpdate = tgt; takenUpdate = taken;
    typeUpdate = 2'(typ); mispredict = mp; reset = rst;
    @(negedge clk); #1;
    we = 1'b0; mispredict = 1'b0; reset = 1'b0;
    if (rst) m_reset();
    else m_update(pc, tgt, taken, typ, mp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    m_reset();
  endtask

  task automatic lookup(input logic [63:0] pc, output logic [63:0] pred, output logic tk);
    @(posedge clk); #1 PC = pc;
    #1 pred = PCPrediction; tk = predTaken;
  endtask

  task automatic check_vs_model(input string name, input logic [63:0] pc);
    logic [63:0] got, exp;
    logic got_tk, exp_tk;
    lookup(pc, got, got_tk);
    m_predict(pc, exp, exp_tk);
    check({name, "_pred"}, got, exp);
    check({name, "_taken"}, 64'(got_tk), 64'(exp_tk));
  endtask

  typedef enum {OpUpd, OpLook} op_e;
  typedef struct {
    op_e         op;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        taken;
    int          typ;
    logic [63:0] exp_pred;
    logic        exp_taken;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t upd(input logic [63:0] pc, input logic [63:0] tgt, input logic taken, input int typ);
    vec_t v;
    v.op = OpUpd; v.pc = pc; v.tgt = tgt; v.taken = taken; v.typ = typ; v.exp_pred = '0; v.exp_taken = 0;
    return v;
  endfunction

  function automatic vec_t look(input logic [63:0] pc, input logic [63:0] ep, input logic et);
    vec_t v;
    v.op = OpLook; v.pc = pc; v.tgt = '0; v.taken = 0; v.typ = 0; v.exp_pred = ep; v.exp_taken = et;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    logic        tk;

    // Reset state
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    m_reset();
    lookup(64'h1000, got, tk);
    check("reset_pred", got, 64'h1004);
    check("reset_taken", 64'(tk), 64'd0);
    check("reset_branch_count", 64'(branchCount), 64'd0);
    check("reset_mispredict_count", 64'(mispredictCount), 64'd0);

    // Directed table: gshare training, non-allocating not-taken branch, tags, call/return
    for (int i = 0; i < 10; i++) vecs.push_back(upd(64'h1000, 64'h2000, 1, 0));
    vecs.push_back(look(64'h1000, 64'h2000, 1));
    vecs.push_back(upd(64'h3000, 64'h5000, 0, 0));
    vecs.push_back(look(64'h3000, 64'h3004, 0));
    vecs.push_back(look(64'h1000, 64'h1004, 0));   // history changed, PHT entry untrained
    vecs.push_back(upd(64'h1100, 64'h4000, 1, 2));
    vecs.push_back(look(64'h1100, 64'h4000, 1));
    vecs.push_back(look(64'h1000, 64'h1004, 0));   // same BTB line, different tag
    vecs.push_back(upd(64'h4010, 64'h9000, 1, 3));
    vecs.push_back(look(64'h4010, 64'h9000, 1));
    vecs.push_back(upd(64'h1100, 64'h4000, 1, 2));
    vecs.push_back(look(64'h4010, 64'h1104, 1));
    vecs.push_back(upd(64'h4010, 64'h9000, 1, 3));
    vecs.push_back(look(64'h4010, 64'h9000, 1));
    vecs.push_back(upd(64'h5000, 64'h6000, 1, 1));
    vecs.push_back(look(64'h5000, 64'h6000, 1));
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].op == OpUpd) begin
        do_update(vecs[i].pc, vecs[i].tgt, vecs[i].taken, vecs[i].typ, 1'b0, 1'b0);
      end else begin
        lookup(vecs[i].pc, got, tk);
        check($sformatf("vec%0d_pred", i), got, vecs[i].exp_pred);
        check($sformatf("vec%0d_taken", i), 64'(tk), 64'(vecs[i].exp_taken));
      end
    end

    // RAS overflow: RAS_DEPTH+1 calls, newest RAS_DEPTH come back in reverse order
    for (int k = 1; k <= RAS_DEPTH + 1; k++) do_update(64'(k) * 64'h100, 64'h8000, 1, 2, 1'b0, 1'b0);
    for (int j = 0; j < RAS_DEPTH; j++) begin
      lookup(64'h4010, got, tk);
      check($sformatf("ras_pop%0d", j), got, 64'(RAS_DEPTH + 1 - j) * 64'h100 + 64'd4);
      do_update(64'h4010, 64'h9000, 1, 3, 1'b0, 1'b0);
    end
    lookup(64'h4010, got, tk);
    check("ras_empty_pred", got, 64'h9000);
    do_update(64'h4010, 64'h9000, 1, 3, 1'b0, 1'b0);
    lookup(64'h4010, got, tk);
    check("ras_empty_pop_pred", got, 64'h9000);
    check_vs_model("ras_empty_model", 64'h4010);

    // Performance counters
    do_reset();
    do_update(64'h1000, 64'h2000, 1, 0, 1'b0, 1'b0);
    do_update(64'h1040, 64'h2040, 0, 0, 1'b1, 1'b0);
    do_update(64'h1080, 64'h2080, 1, 0, 1'b0, 1'b0);
    #1;
    check("cnt_branch_3", 64'(branchCount), 64'd3);
    check("cnt_mispredict_1", 64'(mispredictCount), 64'd1);
    do_update(64'h5000, 64'h6000, 1, 1, 1'b1, 1'b0);
    #1;
    check("cnt_branch_after_jump", 64'(branchCount), 64'd3);
    check("cnt_mispredict_after_jump", 64'(mispredictCount), 64'd2);

    // Reset in the same cycle as a taken-branch update
    do_update(64'h1000, 64'h2000, 1, 0, 1'b0, 1'b0);
    do_update(64'h1000, 64'h2000, 1, 0, 1'b1, 1'b1);
    lookup(64'h1000, got, tk);
    check("rst_upd_pred", got, 64'h1004);
    check("rst_upd_taken", 64'(tk), 64'd0);
    check("rst_upd_branch_count", 64'(branchCount), 64'd0);
    check("rst_upd_mispredict_count", 64'(mispredictCount), 64'd0);
    for (int i = 0; i < 4; i++) begin
      do_update(64'h1000 + 64'(i) * 4, 64'h2000, 1, 0, 1'b0, 1'b0);
      check_vs_model($sformatf("rst_follow%0d", i), 64'h1000 + 64'(i) * 4);
    end

    // Random traffic against the model
    for (int n = 0; n < 900; n++) begin
      logic [63:0] pc, tgt;
      int typ;
      pc = 64'h0001_0000 + 64'($urandom_range(0, 47)) * 64'd12;
      if ($urandom_range(0, 7) == 0) pc[63] = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        typ = $urandom_range(0, 3);
        tgt = {32'h0, $urandom} & ~64'h3;
        do_update(pc, tgt, (typ != 0) ? 1'b1 : 1'($urandom_range(0, 1)), typ,
                  1'($urandom_range(0, 3) == 0), 1'b0);
      end else begin
        check_vs_model($sformatf("rand%0d", n), pc);
      end
      if (n % 100 == 99) begin
        #1;
        check($sformatf("rand_branch_count%0d", n), 64'(branchCount), 64'(m_branches));
        check($sformatf("rand_mispredict_count%0d", n), 64'(mispredictCount), 64'(m_mispredicts));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
